// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 8-digit 7-segment scan controller.
//   - seg7_state_e : scan FSM states
//   - Reg*         : register indices selected by bus_addr[3:2]
//   - Ctrl*        : CTRL field positions and reset value
//   - hex7()       : 4-bit nibble -> active-high segments, a..g on [6:0]
package seg7_pkg;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} seg7_state_e;

  // Register index = bus_addr[3:2]
  localparam logic [1:0] RegData = 2'd0;  // byte offset 0x0
  localparam logic [1:0] RegCtrl = 2'd1;  // byte offset 0x4

  localparam int unsigned CtrlW         = 17;
  localparam int unsigned CtrlDpLsb     = 0;
  localparam int unsigned CtrlDigEnLsb  = 8;
  localparam int unsigned CtrlDispEnBit = 16;
  localparam logic [31:0] CtrlReset     = 32'h0001_FF00;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: purely combinational hex digit decoder.
//   nibble_i [3:0] : hex value
//   seg_o    [6:0] : active-high segments, a on [6] .. g on [0]
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex7(nibble_i);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped scan controller for an 8-digit 7-segment display.
// Holds a 32-bit hex value (DATA) and control (CTRL) and time-multiplexes the
// digits onto AN/A2G/DP. Each digit slot starts with BLANK_CYCLES of all-anodes-off
// followed by SCAN_DIV-BLANK_CYCLES of drive. DATA/CTRL are copied into shadow
// registers only at frame boundaries so a displayed frame is never torn.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus_sel/we    : chip select and write strobe
//   bus_addr[3:0] : byte offset, [3:2] selects DATA(0x0)/CTRL(0x4)/reserved
//   bus_wdata     : write data; bus_rdata: combinational read data
//   AN[7:0]       : anodes, active-low one-cold
//   A2G[6:0]      : segments a..g, active-low
//   DP            : decimal point, active-low
// Optional build macro SEG7_ZERO_BLANK_EN: blank leading-zero digits above the
// highest nonzero shadow nibble (digit 0 always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [3:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  AN,
  output logic [6:0]  A2G,
  output logic        DP
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(SCAN_DIV - BLANK_CYCLES - 1);

  // Bus-visible registers
  logic [31:0]      data_q, data_d;
  logic [CtrlW-1:0] ctrl_q, ctrl_d;
  // Frame shadows
  logic [31:0]      sh_data_q, sh_data_d;
  logic [CtrlW-1:0] sh_ctrl_q, sh_ctrl_d;
  // Scan state
  seg7_state_e      state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Registered outputs
  logic [7:0]       an_q, an_d;
  logic [6:0]       a2g_q, a2g_d;
  logic             dp_q, dp_d;

  logic             load_shadow;
  logic             disp_en_live;
  logic [7:0]       sh_dp_mask, sh_dig_en;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;
  logic             digit_blank;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^bus_addr[1:0];

  assign disp_en_live = ctrl_q[CtrlDispEnBit];
  assign sh_dp_mask   = sh_ctrl_q[CtrlDpLsb +: 8];
  assign sh_dig_en    = sh_ctrl_q[CtrlDigEnLsb +: 8];
  assign cur_nibble   = sh_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg)
  );

`ifdef SEG7_ZERO_BLANK_EN
  logic [2:0] top_nz;
  always_comb begin
    top_nz = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (sh_data_q[4*i +: 4] != 4'h0) top_nz = 3'(i);
    end
  end
  assign digit_blank = (idx_q > top_nz);
`else
  assign digit_blank = 1'b0;
`endif

  // Register writes and reads
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (bus_sel && bus_we) begin
      if (bus_addr[3:2] == RegData) data_d = bus_wdata;
      if (bus_addr[3:2] == RegCtrl) ctrl_d = bus_wdata[CtrlW-1:0];
    end
  end

  always_comb begin
    bus_rdata = 32'h0;
    case (bus_addr[3:2])
      RegData: bus_rdata = data_q;
      RegCtrl: bus_rdata = {{(32 - CtrlW){1'b0}}, ctrl_q};
      default: bus_rdata = 32'h0;
    endcase
  end

  // Scan FSM next state
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    load_shadow = 1'b0;
    if (!disp_en_live) begin
      // Live disable wins from any state, even mid-slot.
      state_d = StIdle;
      idx_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d     = StBlank;
          idx_d       = 3'd0;
          cnt_d       = '0;
          load_shadow = 1'b1;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StDrive;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StDrive: begin
          if (cnt_q == DriveLast) begin
            state_d = StBlank;
            cnt_d   = '0;
            idx_d   = idx_q + 3'd1;
            // Wrapping back to digit 0 is the frame boundary.
            load_shadow = (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    sh_data_d = load_shadow ? data_q : sh_data_q;
    sh_ctrl_d = load_shadow ? ctrl_q : sh_ctrl_q;
  end

  // Outputs are computed from the current state and registered, so they trail
  // the state by one cycle. A live disable blanks them on the same edge.
  always_comb begin
    an_d  = 8'hFF;
    a2g_d = 7'h7F;
    dp_d  = 1'b1;
    if (disp_en_live && state_q == StDrive) begin
      if (sh_dig_en[idx_q]) an_d[idx_q] = 1'b0;
      a2g_d = digit_blank ? 7'h7F : ~cur_seg;
      dp_d  = ~sh_dp_mask[idx_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= 32'h0;
      ctrl_q    <= CtrlReset[CtrlW-1:0];
      sh_data_q <= 32'h0;
      sh_ctrl_q <= CtrlReset[CtrlW-1:0];
      state_q   <= StBlank;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      an_q      <= 8'hFF;
      a2g_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      sh_data_q <= sh_data_d;
      sh_ctrl_q <= sh_ctrl_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      an_q      <= an_d;
      a2g_q     <= a2g_d;
      dp_q      <= dp_d;
    end
  end

  assign AN  = an_q;
  assign A2G = a2g_q;
  assign DP  = dp_q;

endmodule
